// File: rtl/butterfly_pkg.sv
// Shared types and constants for the ButterFly instruction-fetch stage.
// Contents: reset/NOP constants, the fetch FSM state type, and the queue entry payload.
package butterfly_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        misalign;
    } fetch_entry_t;

endpackage

// File: rtl/butterfly_fetch_fifo.sv
// In-order instruction queue for the fetch stage.
// Ports:
//   i_clk, i_rst   clock and synchronous active-high reset
//   i_flush        drop all entries (takes priority over push/pop)
//   i_push/i_data  enqueue one fetch_entry_t
//   i_pop          dequeue the head entry
//   o_head         head entry (valid when !o_empty)
//   o_count        occupancy; o_full / o_empty status
module butterfly_fetch_fifo
    import butterfly_pkg::*;
#(
    parameter  int unsigned FIFO_DEPTH = 2,
    localparam int unsigned AW         = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1,
    localparam int unsigned CW         = AW + 1
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_flush,
    input  logic          i_push,
    input  fetch_entry_t  i_data,
    input  logic          i_pop,
    output fetch_entry_t  o_head,
    output logic [CW-1:0] o_count,
    output logic          o_full,
    output logic          o_empty
);

    fetch_entry_t  r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= r_count + CW'(i_push) - CW'(i_pop);
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_full  = (r_count == CW'(FIFO_DEPTH));
    assign o_empty = (r_count == '0);

endmodule

// File: rtl/butterfly_fetch_unit.sv
// ButterFly RV32IM instruction-fetch stage: owns the fetch PC, issues word
// requests to instruction memory, queues responses in order and hands them
// to decode over valid/ready. A branch redirect flushes the queue and drops
// every response still in flight.
// Ports:
//   clk_i, rst_i                      clock, synchronous active-high reset
//   redirect_valid_i, redirect_pc_i   taken branch/jump and its target
//   imem_req_o, imem_addr_o           request valid and word address
//   imem_gnt_i                        request accepted
//   imem_rvalid_i, imem_rdata_i       in-order response
//   if_valid_o, if_ready_i            decode handshake
//   if_pc_o, if_instr_o, if_misalign_o  presented instruction
// Build option: BUTTERFLY_FETCH_ALIGN_CHECK_EN turns a misaligned redirect
// into a single flagged NOP followed by idling; without it the target's low
// two bits are ignored and if_misalign_o is constant 0.
module butterfly_fetch_unit
    import butterfly_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        redirect_valid_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        if_valid_o,
    input  logic        if_ready_i,
    output logic [31:0] if_pc_o,
    output logic [31:0] if_instr_o,
    output logic        if_misalign_o
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned SW = CW + 1;

    fetch_state_e  r_state;
    fetch_state_e  w_state_next;
    logic [31:0]   r_pc;
    logic [31:0]   r_rsp_pc;
    logic [CW-1:0] r_outstanding;
    logic [CW-1:0] r_drop_cnt;
    logic [CW-1:0] w_pending;
    logic          w_req;
    logic          w_accept;
    logic          w_rsp_drop;
    logic          w_rsp_ok;
    logic          w_have;
    logic          w_pop;
    logic          w_bypass;
    logic          w_push_rsp;
    logic          w_push_mis;
    logic          w_fifo_push;
    logic          w_fifo_pop;
    logic          w_fifo_full;
    logic          w_fifo_empty;
    logic [CW-1:0] w_fifo_count;
    logic [31:0]   w_redirect_pc;
    logic          w_halt;
    logic          w_mis_pend;
    fetch_entry_t  w_rsp_entry;
    fetch_entry_t  w_mis_entry;
    fetch_entry_t  w_push_entry;
    fetch_entry_t  w_fifo_head;
    fetch_entry_t  w_head;

    // FSM state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= BOOT;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state and request issue; in-flight plus queued never exceeds the queue depth.
    always_comb begin
        w_state_next = r_state;
        w_req        = 1'b0;
        case (r_state)
            BOOT: w_state_next = RUN;
            RUN: w_req = !rst_i && !redirect_valid_i && !w_halt && !w_mis_pend &&
                         ((SW'(w_fifo_count) + SW'(r_outstanding)) < SW'(FIFO_DEPTH));
            default: w_state_next = BOOT;
        endcase
    end

    assign imem_req_o  = w_req;
    assign imem_addr_o = r_pc;
    assign w_accept    = w_req && imem_gnt_i;

    // Responses still owed by memory after this cycle; all of them become stale on redirect/reset.
    assign w_pending  = r_outstanding + CW'(w_accept) - CW'(imem_rvalid_i);
    assign w_rsp_drop = imem_rvalid_i && (r_drop_cnt != '0);
    assign w_rsp_ok   = imem_rvalid_i && !w_rsp_drop && !redirect_valid_i && !rst_i;

    assign w_rsp_entry = fetch_entry_t'({r_rsp_pc, imem_rdata_i, 1'b0});
    assign w_mis_entry = fetch_entry_t'({r_pc, NOP_INSTR, 1'b1});

    // An empty queue forwards the arriving response straight to decode.
    assign w_head     = w_fifo_empty ? w_rsp_entry : w_fifo_head;
    assign w_have     = !w_fifo_empty || w_rsp_ok;
    assign if_valid_o = w_have && !redirect_valid_i;
    assign w_pop      = if_valid_o && if_ready_i;
    assign w_bypass   = w_fifo_empty && w_rsp_ok && w_pop;
    assign w_fifo_pop = w_pop && !w_fifo_empty;

    assign w_push_rsp   = w_rsp_ok && !w_bypass;
    assign w_push_mis   = w_mis_pend && !redirect_valid_i;
    assign w_push_entry = w_push_mis ? w_mis_entry : w_rsp_entry;
    assign w_fifo_push  = (w_push_rsp || w_push_mis) && (!w_fifo_full || w_fifo_pop);

    assign if_pc_o    = w_have ? w_head.pc : 32'h0;
    assign if_instr_o = w_have ? w_head.instr : 32'h0;

    // Fetch/response pointers and the outstanding/drop bookkeeping.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_pc          <= RESET_PC;
            r_rsp_pc      <= RESET_PC;
            r_outstanding <= w_pending;
            r_drop_cnt    <= w_pending;
        end else begin
            r_outstanding <= w_pending;
            if (redirect_valid_i) begin
                r_pc       <= w_redirect_pc;
                r_rsp_pc   <= w_redirect_pc;
                r_drop_cnt <= w_pending;
            end else begin
                if (w_accept) begin
                    r_pc <= r_pc + 32'd4;
                end
                if (w_rsp_ok) begin
                    r_rsp_pc <= r_rsp_pc + 32'd4;
                end
                if (w_rsp_drop) begin
                    r_drop_cnt <= r_drop_cnt - CW'(1);
                end
            end
        end
    end

`ifdef BUTTERFLY_FETCH_ALIGN_CHECK_EN
    logic r_halt;
    logic r_mis_pend;

    // A misaligned target queues one flagged NOP next cycle, then fetch idles until the next redirect.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_halt     <= 1'b0;
            r_mis_pend <= 1'b0;
        end else if (redirect_valid_i) begin
            r_halt     <= (redirect_pc_i[1:0] != 2'b00);
            r_mis_pend <= (redirect_pc_i[1:0] != 2'b00);
        end else begin
            r_mis_pend <= 1'b0;
        end
    end

    assign w_redirect_pc = redirect_pc_i;
    assign w_halt        = r_halt;
    assign w_mis_pend    = r_mis_pend;
    assign if_misalign_o = w_have && w_head.misalign;
`else
    logic [2:0] w_unused_bits;

    assign w_redirect_pc = {redirect_pc_i[31:2], 2'b00};
    assign w_halt        = 1'b0;
    assign w_mis_pend    = 1'b0;
    assign if_misalign_o = 1'b0;
    assign w_unused_bits = {redirect_pc_i[1:0], w_head.misalign};
`endif

    butterfly_fetch_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (clk_i),
        .i_rst   (rst_i),
        .i_flush (redirect_valid_i),
        .i_push  (w_fifo_push),
        .i_data  (w_push_entry),
        .i_pop   (w_fifo_pop),
        .o_head  (w_fifo_head),
        .o_count (w_fifo_count),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

endmodule

// File: tb/tb_butterfly_fetch_unit.sv
// Self-checking bench for butterfly_fetch_unit: randomized memory timing,
// decode back-pressure, redirects and resets, with an expected instruction
// stream (scoreboard queue) derived from the program-order fetch rule.
module tb_butterfly_fetch_unit;
    import butterfly_pkg::*;

    localparam int unsigned DEPTH = 2;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        redirect_valid_i = 1'b0;
    logic [31:0] redirect_pc_i = 32'h0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i = 1'b0;
    logic        imem_rvalid_i = 1'b0;
    logic [31:0] imem_rdata_i = 32'h0;
    logic        if_valid_o;
    logic        if_ready_i = 1'b0;
    logic [31:0] if_pc_o;
    logic [31:0] if_instr_o;
    logic        if_misalign_o;

    always #5 clk_i = ~clk_i;

    butterfly_fetch_unit #(.RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .redirect_valid_i(redirect_valid_i), .redirect_pc_i(redirect_pc_i),
        .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
        .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
        .if_valid_o(if_valid_o), .if_ready_i(if_ready_i),
        .if_pc_o(if_pc_o), .if_instr_o(if_instr_o), .if_misalign_o(if_misalign_o)
    );

    int          checks = 0;
    int          errors = 0;
    int unsigned cyc = 0;
    int unsigned gnt_pct = 100, rdy_pct = 100, lat_min = 1, lat_max = 1;
    int          live = 0;
    logic        halted_m = 1'b0;
    logic        boot_cycle = 1'b0, boot_next = 1'b0;
    logic [31:0] next_fetch = RST_PC;
    fetch_entry_t exp_q[$];
    logic [31:0]  inf_addr[$];
    int unsigned  inf_due[$];

    always @(posedge clk_i) cyc <= cyc + 1;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0013;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected program-order stream after a reset or redirect to tgt.
    task automatic restart(input logic [31:0] tgt);
        logic [31:0] t;
        exp_q.delete();
        live = 0;
        halted_m = 1'b0;
`ifdef BUTTERFLY_FETCH_ALIGN_CHECK_EN
        if (tgt[1:0] != 2'b00) begin
            exp_q.push_back(fetch_entry_t'({tgt, NOP_INSTR, 1'b1}));
            halted_m = 1'b1;
            return;
        end
`endif
        t = {tgt[31:2], 2'b00};
        next_fetch = t;
        for (int i = 0; i < 64; i++) begin
            exp_q.push_back(fetch_entry_t'({t, mem_word(t), 1'b0}));
            t = t + 32'd4;
        end
    endtask

    // Instruction memory: in-order responses, latency >= 1 cycle after grant.
    task automatic drive_mem();
        imem_gnt_i = ($urandom_range(99, 0) < gnt_pct);
        if_ready_i = ($urandom_range(99, 0) < rdy_pct);
        if (inf_due.size() > 0 && inf_due[0] <= cyc) begin
            imem_rvalid_i = 1'b1;
            imem_rdata_i  = mem_word(inf_addr.pop_front());
            void'(inf_due.pop_front());
        end else begin
            imem_rvalid_i = 1'b0;
            imem_rdata_i  = $urandom;
        end
    endtask

    task automatic cycle(input logic redir, input logic [31:0] tgt);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        boot_cycle = boot_next;
        boot_next = 1'b0;
        redirect_valid_i = redir;
        redirect_pc_i = redir ? tgt : $urandom;
        if (redir) restart(tgt);
        drive_mem();
    endtask

    task automatic reset_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_i);
            #1;
            rst_i = 1'b1;
            boot_cycle = 1'b0;
            redirect_valid_i = 1'b0;
            restart(RST_PC);
            drive_mem();
            if (i > 0) begin
                @(negedge clk_i);
                check("rst_req", imem_req_o, 0);
                check("rst_valid", if_valid_o, 0);
                check("rst_pc", if_pc_o, 0);
                check("rst_instr", if_instr_o, 0);
                check("rst_misalign", if_misalign_o, 0);
            end
        end
        boot_next = 1'b1;
    endtask

    // Request-side monitor: records accepted fetches and checks issue rules.
    logic        pend_req = 1'b0;
    logic [31:0] pend_addr = 32'h0;
    always @(negedge clk_i) begin
        if (rst_i) begin
            pend_req = 1'b0;
        end else begin
            if (redirect_valid_i) check("req_on_redirect", imem_req_o, 0);
            if (boot_cycle) check("req_in_boot", imem_req_o, 0);
            if (halted_m && !redirect_valid_i) check("req_while_halted", imem_req_o, 0);
            if (pend_req && !redirect_valid_i) begin
                check("req_held", imem_req_o, 1);
                check("addr_held", imem_addr_o, pend_addr);
            end
            if (imem_req_o && imem_gnt_i) begin
                int unsigned d;
                check("fetch_addr", imem_addr_o, next_fetch);
                next_fetch = next_fetch + 32'd4;
                live++;
                check("credit_cap", (live <= int'(DEPTH)) ? 1 : 0, 1);
                d = cyc + $urandom_range(lat_max, lat_min);
                if (inf_due.size() > 0 && d <= inf_due[$]) d = inf_due[$] + 1;
                inf_addr.push_back(imem_addr_o);
                inf_due.push_back(d);
            end
            pend_req  = imem_req_o && !imem_gnt_i;
            pend_addr = imem_addr_o;
        end
    end

    // Decode-side monitor: pops the scoreboard on every completed handshake.
    logic        hold_prev = 1'b0;
    logic [31:0] hold_pc = 32'h0, hold_instr = 32'h0;
    always @(negedge clk_i) begin
        if (rst_i) begin
            hold_prev = 1'b0;
        end else begin
            if (hold_prev && !redirect_valid_i) begin
                check("hold_valid", if_valid_o, 1);
                check("hold_pc", if_pc_o, hold_pc);
                check("hold_instr", if_instr_o, hold_instr);
            end
            if (if_valid_o && if_ready_i) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_instr: got pc %h instr %h, expected no instruction", if_pc_o, if_instr_o);
                end else begin
                    fetch_entry_t e;
                    e = exp_q.pop_front();
                    check("if_pc", if_pc_o, e.pc);
                    check("if_instr", if_instr_o, e.instr);
                    check("if_misalign", if_misalign_o, e.misalign);
                    live--;
                end
            end
            hold_prev  = if_valid_o && !if_ready_i;
            hold_pc    = if_pc_o;
            hold_instr = if_instr_o;
        end
    end

    initial begin
        int since;
        logic seen;

        // Startup: BOOT cycle, then 0x0/0x4/0x8 back to back.
        gnt_pct = 100; rdy_pct = 100; lat_min = 1; lat_max = 1;
        reset_cycles(3);
        cycle(1'b0, 0); @(negedge clk_i); check("boot_valid", if_valid_o, 0);
        cycle(1'b0, 0); @(negedge clk_i); check("first_req", imem_req_o, 1); check("first_addr", imem_addr_o, 32'h0);
        cycle(1'b0, 0); @(negedge clk_i); check("lat_v0", if_valid_o, 1); check("lat_pc0", if_pc_o, 32'h0);
        cycle(1'b0, 0); @(negedge clk_i); check("lat_v1", if_valid_o, 1); check("lat_pc1", if_pc_o, 32'h4);
        cycle(1'b0, 0); @(negedge clk_i); check("lat_v2", if_valid_o, 1); check("lat_pc2", if_pc_o, 32'h8);

        // Decode stalled: two fetches fill the queue, requests stop.
        rdy_pct = 0;
        reset_cycles(2);
        for (int i = 0; i < 12; i++) cycle(1'b0, 0);
        @(negedge clk_i);
        check("stall_req", imem_req_o, 0);
        check("stall_valid", if_valid_o, 1);
        check("stall_pc", if_pc_o, 32'h0);
        rdy_pct = 100;
        for (int i = 0; i < 6; i++) cycle(1'b0, 0);

        // Two in flight at 3-cycle latency, then redirect to 0x100.
        lat_min = 3; lat_max = 3;
        reset_cycles(2);
        for (int i = 0; i < 3; i++) cycle(1'b0, 0);
        cycle(1'b1, 32'h100);
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            cycle(1'b0, 0);
            @(negedge clk_i);
            if (if_valid_o && if_ready_i) begin
                seen = 1'b1;
                check("redir_pc", if_pc_o, 32'h100);
                check("redir_instr", if_instr_o, mem_word(32'h100));
            end
        end
        if (!seen) check("redir_timeout", 0, 1);

        // Redirect during a streaming cycle (grant + response): best-case latency.
        lat_min = 1; lat_max = 1;
        cycle(1'b1, 32'h200);
        for (int i = 0; i < 12; i++) cycle(1'b0, 0);
        cycle(1'b1, 32'h240);
        cycle(1'b0, 0); @(negedge clk_i);
        check("bc_valid_n1", if_valid_o, 0);
        check("bc_req_n1", imem_req_o, 1);
        check("bc_addr_n1", imem_addr_o, 32'h240);
        cycle(1'b0, 0); @(negedge clk_i);
        check("bc_valid_n2", if_valid_o, 1);
        check("bc_pc_n2", if_pc_o, 32'h240);

        // Address wrap at the top of memory.
        cycle(1'b1, 32'hFFFF_FFF4);
        for (int i = 0; i < 10; i++) cycle(1'b0, 0);

        // Misaligned target: flagged NOP and idle (or low bits ignored).
        rdy_pct = 60;
        cycle(1'b1, 32'h102);
        for (int i = 0; i < 12; i++) cycle(1'b0, 0);
`ifdef BUTTERFLY_FETCH_ALIGN_CHECK_EN
        check("mis_drained", exp_q.size(), 0);
`endif
        cycle(1'b1, 32'h200);
        for (int i = 0; i < 10; i++) cycle(1'b0, 0);

        // Randomized traffic, redirects and resets.
        since = 0;
        for (int i = 0; i < 4000; i++) begin
            if (i % 200 == 0) begin
                gnt_pct = $urandom_range(100, 30);
                rdy_pct = $urandom_range(100, 20);
                lat_min = $urandom_range(2, 1);
                lat_max = lat_min + $urandom_range(3, 0);
            end
            if ($urandom_range(999, 0) < 3) begin
                reset_cycles($urandom_range(2, 1));
                since = 0;
            end else if (since >= 45 || $urandom_range(99, 0) < 5) begin
                logic [31:0] t;
                case ($urandom_range(9, 0))
                    0: t = 32'hFFFF_FFE0 + 32'($urandom_range(7, 0) * 4);
                    1: t = $urandom;
                    default: t = {20'h0, 10'($urandom_range(1023, 0)), 2'b00};
                endcase
                cycle(1'b1, t);
                since = 0;
            end else begin
                cycle(1'b0, 0);
                since++;
            end
        end
        cycle(1'b0, 0);
        @(negedge clk_i);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
